// File: rtl/lvdc_bufreg_pkg.sv
// lvdc_bufreg_pkg: shared state type, default geometry and channel OR helper for the buffer register
package lvdc_bufreg_pkg;
    typedef enum logic {BR_IDLE, BR_SHIFT} bufreg_state_t;
    localparam int DEF_WIDTH = 13;
    localparam int DEF_N_MOD = 4;
    localparam int MAX_MOD = 16;
    localparam logic [DEF_WIDTH-1:0] DEF_Y_MASK = 13'h1FFF & ~13'h0249;
    // One BR bit column: OR of that bit across all enabled sense-amp channels
    function automatic logic or_reduce_channels(input logic [MAX_MOD-1:0] col, input logic [MAX_MOD-1:0] en);
        return |(col & en);
    endfunction
endpackage

// File: rtl/bufreg_shift_ctl.sv
// bufreg_shift_ctl: IDLE/SHIFT sequencer with bit counter for serial shift-out of the buffer register
module bufreg_shift_ctl
    import lvdc_bufreg_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic v1,
    input  logic clr_n,
    input  logic start,
    output logic shift_en,
    output logic busy,
    output logic done
);
    bufreg_state_t state;
    logic [CNT_W-1:0] cnt;
    logic last;
    assign shift_en = (state == BR_SHIFT) & v1 & clr_n;
    assign last = shift_en & (cnt == CNT_W'(WIDTH - 1));
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= BR_IDLE;
            cnt <= '0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= last;
            if (v1) begin
                if (state == BR_IDLE) begin
                    if (start & clr_n) begin
                        state <= BR_SHIFT;
                        busy <= 1'b1;
                        cnt <= '0;
                    end
                end else if (!clr_n || last) begin
                    state <= BR_IDLE;
                    busy <= 1'b0;
                    cnt <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/buffer_register_param.sv
// buffer_register_param: WIDTH-bit buffer register with sense-amp OR load, split TR load and serial shift-out.
// Optional BUFREG_PARITY_EN adds SA_PAR input and a sticky per-channel odd-parity error flag.
module buffer_register_param
    import lvdc_bufreg_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int N_MOD = DEF_N_MOD,
    parameter logic [WIDTH-1:0] Y_MASK = DEF_Y_MASK,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic                   SIM_CLK,
    input  logic                   SIM_RST,
    input  logic                   V1,
    input  logic                   CBRVN,
    input  logic                   SBRYV,
    input  logic                   SBRZV,
    input  logic [WIDTH-1:0]       TR,
    input  logic [N_MOD*WIDTH-1:0] SA,
    input  logic [N_MOD-1:0]       MOD_EN,
`ifdef BUFREG_PARITY_EN
    input  logic [N_MOD-1:0]       SA_PAR,
`endif
    input  logic                   SHIFT_START,
    input  logic                   SHIFT_IN,
    output logic [WIDTH-1:0]       BR,
    output logic [WIDTH-1:0]       BRN,
    output logic                   SHIFT_OUT,
    output logic                   BUSY,
    output logic                   DONE,
    output logic                   PAR_ERR
);
    logic [WIDTH-1:0] br, sense, trld;
    logic shift_en;
    bufreg_shift_ctl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_ctl (
        .clk(SIM_CLK),
        .rst_n(SIM_RST),
        .v1(V1),
        .clr_n(CBRVN),
        .start(SHIFT_START),
        .shift_en(shift_en),
        .busy(BUSY),
        .done(DONE)
    );
    always_comb begin
        logic [MAX_MOD-1:0] col, en_ext;
        en_ext = '0;
        en_ext[N_MOD-1:0] = MOD_EN;
        sense = '0;
        for (int b = 0; b < WIDTH; b++) begin
            col = '0;
            for (int k = 0; k < N_MOD; k++) col[k] = SA[k*WIDTH+b];
            sense[b] = or_reduce_channels(col, en_ext);
        end
    end
    assign trld = TR & ((Y_MASK & {WIDTH{SBRYV}}) | (~Y_MASK & {WIDTH{SBRZV}}));
    // A strobe that launches a shift holds BR so the first serial bit is the loaded LSB
    always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
        if (!SIM_RST) br <= '0;
        else if (V1) begin
            if (shift_en) br <= {SHIFT_IN, br[WIDTH-1:1]};
            else if (BUSY) br <= '0;
            else if (!(SHIFT_START & CBRVN)) br <= (CBRVN ? br : '0) | sense | trld;
        end
    end
    assign BR = br;
    assign BRN = ~br;
    assign SHIFT_OUT = br[0];
`ifdef BUFREG_PARITY_EN
    logic par_err, par_bad;
    always_comb begin
        par_bad = 1'b0;
        for (int k = 0; k < N_MOD; k++) par_bad = par_bad | (MOD_EN[k] & ~(^SA[k*WIDTH +: WIDTH] ^ SA_PAR[k]));
    end
    always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
        if (!SIM_RST) par_err <= 1'b0;
        else if (V1 && !BUSY) begin
            if (par_bad) par_err <= 1'b1;
            else if (!CBRVN && MOD_EN == '0) par_err <= 1'b0;
        end
    end
    assign PAR_ERR = par_err;
`else
    assign PAR_ERR = 1'b0;
`endif
endmodule

// File: tb/tb_buffer_register_param.sv
// tb_buffer_register_param: directed self-checking bench for buffer_register_param (default 13-bit, 4 channels)
module tb_buffer_register_param;
    localparam int W = 13;
    localparam int NM = 4;
    logic SIM_CLK = 1'b0, SIM_RST = 1'b0, V1 = 1'b0, CBRVN = 1'b1, SBRYV = 1'b0, SBRZV = 1'b0;
    logic [W-1:0] TR = '0;
    logic [NM*W-1:0] SA = '0;
    logic [NM-1:0] MOD_EN = '0;
`ifdef BUFREG_PARITY_EN
    logic [NM-1:0] SA_PAR = '0;
`endif
    logic SHIFT_START = 1'b0, SHIFT_IN = 1'b0;
    logic [W-1:0] BR, BRN;
    logic SHIFT_OUT, BUSY, DONE, PAR_ERR;
    int total = 0, bad = 0;

    buffer_register_param dut (
        .SIM_CLK(SIM_CLK), .SIM_RST(SIM_RST), .V1(V1), .CBRVN(CBRVN), .SBRYV(SBRYV), .SBRZV(SBRZV),
        .TR(TR), .SA(SA), .MOD_EN(MOD_EN),
`ifdef BUFREG_PARITY_EN
        .SA_PAR(SA_PAR),
`endif
        .SHIFT_START(SHIFT_START), .SHIFT_IN(SHIFT_IN), .BR(BR), .BRN(BRN),
        .SHIFT_OUT(SHIFT_OUT), .BUSY(BUSY), .DONE(DONE), .PAR_ERR(PAR_ERR)
    );

    always #5 SIM_CLK = ~SIM_CLK;

    task automatic strobe();
        V1 = 1'b1;
        @(posedge SIM_CLK);
        #1 V1 = 1'b0;
    endtask

    task automatic idle_clk();
        @(posedge SIM_CLK);
        #1;
    endtask

    task automatic load_one();
        TR = 13'h0001; SBRZV = 1'b1;
        strobe();
        TR = '0; SBRZV = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        total++; if (BR !== 13'h0000) begin bad++; $display("FAIL reset_br got %h want %h", BR, 13'h0000); end
        total++; if (BRN !== 13'h1FFF) begin bad++; $display("FAIL reset_brn got %h want %h", BRN, 13'h1FFF); end
        total++; if ({BUSY, DONE, PAR_ERR} !== 3'b000) begin bad++; $display("FAIL reset_flags got %b want 000", {BUSY, DONE, PAR_ERR}); end
        idle_clk();
        SIM_RST = 1'b1;
        idle_clk();
    endtask

    task automatic test_sense();
        MOD_EN = 4'b0001; SA = '0; SA[0 +: W] = 13'h0A5;
        strobe();
        total++; if (BR !== 13'h00A5) begin bad++; $display("FAIL sense_ch0 got %h want %h", BR, 13'h00A5); end
        total++; if (BRN !== 13'h1F5A) begin bad++; $display("FAIL sense_brn got %h want %h", BRN, 13'h1F5A); end
        MOD_EN = 4'b0100; SA = '0; SA[2*W +: W] = 13'h100;
        idle_clk();
        total++; if (BR !== 13'h00A5) begin bad++; $display("FAIL no_v1_hold got %h want %h", BR, 13'h00A5); end
        strobe();
        total++; if (BR !== 13'h01A5) begin bad++; $display("FAIL or_accum got %h want %h", BR, 13'h01A5); end
        CBRVN = 1'b0; MOD_EN = 4'b0001; SA = '0; SA[0 +: W] = 13'h0A5;
        strobe();
        total++; if (BR !== 13'h00A5) begin bad++; $display("FAIL clear_plus_load got %h want %h", BR, 13'h00A5); end
        MOD_EN = '0;
        strobe();
        total++; if (BR !== 13'h0000) begin bad++; $display("FAIL clear got %h want %h", BR, 13'h0000); end
        CBRVN = 1'b1; SA = '0;
    endtask

    task automatic test_tr_load();
        TR = 13'h1FFF; SBRZV = 1'b1;
        strobe();
        total++; if (BR !== 13'h0249) begin bad++; $display("FAIL tr_z_half got %h want %h", BR, 13'h0249); end
        SBRZV = 1'b0; SBRYV = 1'b1;
        strobe();
        total++; if (BR !== 13'h1FFF) begin bad++; $display("FAIL tr_y_half got %h want %h", BR, 13'h1FFF); end
        SBRYV = 1'b0; TR = '0; CBRVN = 1'b0;
        strobe();
        CBRVN = 1'b1;
    endtask

    task automatic test_shift();
        logic [W-1:0] exp;
        load_one();
        SHIFT_IN = 1'b0; SHIFT_START = 1'b1; MOD_EN = 4'b0001; SA[0 +: W] = 13'h0A5;
        strobe();
        total++; if (BR !== 13'h0001) begin bad++; $display("FAIL start_suppress got %h want %h", BR, 13'h0001); end
        total++; if (BUSY !== 1'b1) begin bad++; $display("FAIL start_busy got %b want 1", BUSY); end
        TR = 13'h1FFF; SBRYV = 1'b1;
        exp = 13'h0001;
        for (int i = 0; i < W; i++) begin
            total++; if (SHIFT_OUT !== exp[0]) begin bad++; $display("FAIL shift_out[%0d] got %b want %b", i, SHIFT_OUT, exp[0]); end
            if (i == 4) begin
                idle_clk();
                total++; if (BR !== exp) begin bad++; $display("FAIL v1_gap got %h want %h", BR, exp); end
            end
            strobe();
            exp = {1'b0, exp[W-1:1]};
            if (i < W - 1) begin
                total++; if ({BUSY, DONE} !== 2'b10) begin bad++; $display("FAIL shifting[%0d] busy,done got %b want 10", i, {BUSY, DONE}); end
            end
        end
        total++; if ({BUSY, DONE} !== 2'b01) begin bad++; $display("FAIL shift_end busy,done got %b want 01", {BUSY, DONE}); end
        total++; if (BR !== 13'h0000) begin bad++; $display("FAIL shift_end_br got %h want %h", BR, 13'h0000); end
        SHIFT_START = 1'b0; MOD_EN = '0; SA = '0; TR = '0; SBRYV = 1'b0;
        idle_clk();
        total++; if (DONE !== 1'b0) begin bad++; $display("FAIL done_pulse got %b want 0", DONE); end
    endtask

    task automatic test_abort();
        load_one();
        SHIFT_IN = 1'b1; SHIFT_START = 1'b1;
        strobe();
        SHIFT_START = 1'b0;
        strobe();
        total++; if (BR !== 13'h1000) begin bad++; $display("FAIL shift_in_msb got %h want %h", BR, 13'h1000); end
        repeat (3) strobe();
        total++; if (BR !== 13'h1E00) begin bad++; $display("FAIL four_shifts got %h want %h", BR, 13'h1E00); end
        CBRVN = 1'b0;
        strobe();
        total++; if ({BUSY, DONE} !== 2'b00) begin bad++; $display("FAIL abort_flags got %b want 00", {BUSY, DONE}); end
        total++; if (BR !== 13'h0000) begin bad++; $display("FAIL abort_br got %h want %h", BR, 13'h0000); end
        CBRVN = 1'b1;
        idle_clk();
        total++; if (DONE !== 1'b0) begin bad++; $display("FAIL abort_no_done got %b want 0", DONE); end
    endtask

    task automatic test_async_reset();
        SHIFT_IN = 1'b1; SHIFT_START = 1'b1;
        strobe();
        SHIFT_START = 1'b0;
        repeat (6) strobe();
        total++; if (BR !== 13'h1F80) begin bad++; $display("FAIL six_shifts got %h want %h", BR, 13'h1F80); end
        V1 = 1'b1;
        #2 SIM_RST = 1'b0;
        #1;
        total++; if (BR !== 13'h0000 || BRN !== 13'h1FFF) begin bad++; $display("FAIL async_rst br,brn got %h,%h want 0000,1fff", BR, BRN); end
        total++; if ({BUSY, DONE} !== 2'b00) begin bad++; $display("FAIL async_rst_flags got %b want 00", {BUSY, DONE}); end
        V1 = 1'b0; SHIFT_IN = 1'b0;
        idle_clk();
        SIM_RST = 1'b1;
        idle_clk();
        total++; if ({BUSY, DONE} !== 2'b00) begin bad++; $display("FAIL post_rst_flags got %b want 00", {BUSY, DONE}); end
    endtask

    task automatic test_parity();
        total++; if (PAR_ERR !== 1'b0) begin bad++; $display("FAIL par_init got %b want 0", PAR_ERR); end
        MOD_EN = 4'b0010; SA = '0; SA[W +: W] = 13'h003;
`ifdef BUFREG_PARITY_EN
        SA_PAR = 4'b0000;
        strobe();
        total++; if (PAR_ERR !== 1'b1) begin bad++; $display("FAIL par_detect got %b want 1", PAR_ERR); end
        SA[W +: W] = 13'h001;
        strobe();
        total++; if (PAR_ERR !== 1'b1) begin bad++; $display("FAIL par_sticky got %b want 1", PAR_ERR); end
        MOD_EN = '0; CBRVN = 1'b0;
        strobe();
        total++; if (PAR_ERR !== 1'b0) begin bad++; $display("FAIL par_clear got %b want 0", PAR_ERR); end
`else
        strobe();
        total++; if (PAR_ERR !== 1'b0) begin bad++; $display("FAIL par_tied got %b want 0", PAR_ERR); end
`endif
        total++; if (BR !== 13'h0003 && CBRVN) begin bad++; $display("FAIL par_load_br got %h want %h", BR, 13'h0003); end
        MOD_EN = '0; SA = '0; CBRVN = 1'b1;
    endtask

    initial begin
        test_reset();
        test_sense();
        test_tr_load();
        test_shift();
        test_abort();
        test_async_reset();
        test_parity();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
